// File: rtl/pc8001_video_pkg.sv
// pc8001_video_pkg
//   Shared definitions for the PC-8001 video path: arbiter state encoding
//   and the text geometry / VRAM address width used by the arbiter, the
//   line buffer and the video timing logic.
package pc8001_video_pkg;

  localparam int TEXT_COLS = 80;  // characters per text row
  localparam int VRAM_AW   = 12;  // 4 KiB VRAM

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pc8001_line_buffer.sv
// pc8001_line_buffer
//   DEPTH x DW dual-port line buffer. The write side is driven by the
//   arbiter's buf_* strobe during blanking; the read side feeds the
//   character generator with one cycle of read latency.
// Ports:
//   clk, reset            clock, synchronous active-high reset (read reg only)
//   buf_we/addr/data      write port from the display fetch burst
//   rd_addr, rd_data      registered read port
module pc8001_line_buffer
  import pc8001_video_pkg::*;
#(
  parameter int DEPTH = TEXT_COLS,
  parameter int DW    = 8,
  parameter int IW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          buf_we,
  input  logic [IW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic [IW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;

  // Index space may be wider than the buffer; out-of-range writes are dropped
  // and out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (buf_we && (32'(buf_addr) < DEPTH)) mem_q[buf_addr] <= buf_data;
  end

  always_comb begin
    rd_data_d = '0;
    if (32'(rd_addr) < DEPTH) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pc8001_vram_arbiter.sv
// pc8001_vram_arbiter
//   Shares one synchronous VRAM port between the Z80 CPU and a per-row
//   character fetch burst that fills the line buffer during blanking.
//   Pipeline: decision (cycle D) -> mem_* registered, access issued (D+1)
//   -> read data returns (D+2) as cpu_ack / buf_we.
//   During a burst the CPU is forced in after at most CPU_GAP display reads.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      level CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata         completion pulse, read data (held otherwise)
//   fetch_start, fetch_base    burst start pulse and base address
//   fetch_busy/done/overrun    burst status
//   buf_we/addr/data           line-buffer write port
//   mem_addr/we/wdata, mem_rdata  VRAM port (1-cycle read latency)
module pc8001_vram_arbiter
  import pc8001_video_pkg::*;
#(
  parameter int AW        = VRAM_AW,
  parameter int DW        = 8,
  parameter int BURST_LEN = TEXT_COLS,
  parameter int IW        = 7,
  parameter int CPU_GAP   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          fetch_start,
  input  logic [AW-1:0] fetch_base,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          fetch_overrun,
  output logic          buf_we,
  output logic [IW-1:0] buf_addr,
  output logic [DW-1:0] buf_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int IDXW = IW + 1;  // idx must reach BURST_LEN (up to 2^IW)
  localparam int GW   = $clog2(CPU_GAP + 1);
  localparam logic [IDXW-1:0] LEN     = IDXW'(BURST_LEN);
  localparam logic [IDXW-1:0] LAST    = IDXW'(BURST_LEN - 1);
  localparam logic [GW-1:0]   GAP_MAX = GW'(CPU_GAP);

  arb_state_e      state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;

  // issue stage (what mem_* carries this cycle)
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            iss_cpu_q, iss_cpu_d;
  logic            iss_rd_q, iss_rd_d;
  logic            iss_disp_q, iss_disp_d;
  logic            iss_last_q, iss_last_d;
  logic [IW-1:0]   iss_idx_q, iss_idx_d;

  // return stage (mem_rdata belongs to this access)
  logic            ret_cpu_q, ret_rd_q, ret_disp_q, ret_last_q;
  logic [IW-1:0]   ret_idx_q;
  logic [DW-1:0]   rdata_hold_q;

  logic            cpu_ok, grant_cpu, grant_disp;

  // The request is a level held until ack, so it must not be re-granted
  // while its access is still in the issue or return stage.
  assign cpu_ok = cpu_req && !iss_cpu_q && !ret_cpu_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    iss_cpu_d   = 1'b0;
    iss_rd_d    = 1'b0;
    iss_disp_d  = 1'b0;
    iss_last_d  = 1'b0;
    iss_idx_d   = '0;
    grant_cpu   = 1'b0;
    grant_disp  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        grant_cpu = cpu_ok;
        if (fetch_start) begin
          base_d  = fetch_base;
          idx_d   = '0;
          gap_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (cpu_ok && (gap_q == GAP_MAX)) begin
          grant_cpu = 1'b1;
          gap_d     = '0;
        end else if (idx_q < LEN) begin
          grant_disp = 1'b1;
          idx_d      = idx_q + 1'b1;
          if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
        end
        // leave once the last display read has come back
        if (ret_disp_q && ret_last_q) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (grant_cpu) begin
      mem_addr_d  = cpu_addr;
      mem_we_d    = cpu_we;
      mem_wdata_d = cpu_wdata;
      iss_cpu_d   = 1'b1;
      iss_rd_d    = !cpu_we;
    end
    if (grant_disp) begin
      mem_addr_d = base_q + AW'(idx_q);  // wraps mod 2^AW
      iss_disp_d = 1'b1;
      iss_idx_d  = idx_q[IW-1:0];
      iss_last_d = (idx_q == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      iss_cpu_q    <= 1'b0;
      iss_rd_q     <= 1'b0;
      iss_disp_q   <= 1'b0;
      iss_last_q   <= 1'b0;
      iss_idx_q    <= '0;
      ret_cpu_q    <= 1'b0;
      ret_rd_q     <= 1'b0;
      ret_disp_q   <= 1'b0;
      ret_last_q   <= 1'b0;
      ret_idx_q    <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      iss_cpu_q    <= iss_cpu_d;
      iss_rd_q     <= iss_rd_d;
      iss_disp_q   <= iss_disp_d;
      iss_last_q   <= iss_last_d;
      iss_idx_q    <= iss_idx_d;
      ret_cpu_q    <= iss_cpu_q;
      ret_rd_q     <= iss_rd_q;
      ret_disp_q   <= iss_disp_q;
      ret_last_q   <= iss_last_q;
      ret_idx_q    <= iss_idx_q;
      rdata_hold_q <= cpu_rdata;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_ack       = ret_cpu_q;
  assign cpu_rdata     = (ret_cpu_q && ret_rd_q) ? mem_rdata : rdata_hold_q;
  assign fetch_busy    = (state_q == ARB_BURST);
  assign fetch_done    = ret_disp_q && ret_last_q;
  assign fetch_overrun = fetch_start && fetch_busy;
  assign buf_we        = ret_disp_q;
  assign buf_addr      = ret_idx_q;
  assign buf_data      = ret_disp_q ? mem_rdata : '0;

endmodule

// File: doc/pc8001_vram_arbiter.md
Name: pc8001_vram_arbiter

Overview:
- Single-port VRAM arbiter and display-fetch sequencer for the PC-8001 video path.
- Shares one synchronous RAM port between the Z80 CPU access port and a per-row character fetch burst.
- The burst fills the display line buffer during blanking.
- Sits between the CPU bus decoder and the video timing/character generator.
- Guarantees bounded CPU wait during bursts.

Parameters:
AW, 12, VRAM address width
DW, 8, data width
BURST_LEN, 80, reads per fetch burst (1..2^IW)
IW, 7, line-buffer index width
CPU_GAP, 4, max consecutive display reads before a pending CPU request must be granted (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid while cpu_ack
fetch_start  in  1  one-cycle pulse: begin burst
fetch_base  in  AW  burst base address, sampled with fetch_start
fetch_busy  out  1  burst in progress
fetch_done  out  1  one-cycle pulse with the final buf_we
fetch_overrun  out  1  one-cycle pulse: fetch_start arrived while busy
buf_we  out  1  line-buffer write strobe
buf_addr  out  IW  line-buffer index
buf_data  out  DW  line-buffer data
mem_addr  out  AW  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, 1-cycle latency

Behaviour:
- Memory model:
  - One access is issued per clk cycle: mem_addr, mem_we and mem_wdata are registered outputs, valid in issue cycle T.
  - Read data is present on mem_rdata at T+1.
- Reset: all outputs are 0. Burst index, gap counter and pending-ack state clear. A reset mid-burst or mid-access drops the access with no ack and no buf_we; no partial-state recovery.
- States: IDLE, BURST. Arbitration is decided per cycle inside each state.
- IDLE:
  - If cpu_req=1 and cpu_ack=0, issue the CPU access in this cycle.
  - The CPU is never granted in a cycle where cpu_ack=1; this prevents a double issue on the level request.
  - If fetch_start=1, latch fetch_base, set idx=0 and gap=0, then go to BURST next cycle with fetch_busy=1.
  - A CPU grant in the fetch_start cycle is permitted.
- BURST, each cycle, in priority order:
  1. If cpu_req=1, cpu_ack=0 and gap==CPU_GAP: issue the CPU access and set gap=0.
  2. Otherwise, if idx<BURST_LEN: issue a display read at mem_addr=(base+idx) mod 2^AW, mem_we=0; increment idx and gap. gap saturates at CPU_GAP.
  3. Otherwise: idle slot.
- Display data return: at T+1, buf_we=1, buf_addr=idx issued at T, buf_data=mem_rdata.
- Burst completion:
  - When the read with idx=BURST_LEN-1 returns, fetch_done=1 in the same cycle as its buf_we.
  - fetch_busy drops the following cycle and the state returns to IDLE.
- CPU completion: an access issued at T gives cpu_ack=1 at T+1. For reads, cpu_rdata=mem_rdata in that cycle; otherwise cpu_rdata holds its last value.
- Worst-case CPU wait in BURST is CPU_GAP+1 cycles from request to issue.
- fetch_start while fetch_busy=1: ignored, and fetch_overrun=1 for one cycle. The burst in progress is unaffected.
- A pending CPU request at burst end is granted in the first IDLE cycle.
- gap resets to 0 on entry to BURST and does not carry over between bursts.

Decomposition:
- Package pc8001_video_pkg holds:
  - the arbiter state enum (ARB_IDLE, ARB_BURST);
  - constants TEXT_COLS=80 and VRAM_AW=12, shared with the line buffer and timing logic.
- Sub-module pc8001_line_buffer: a BURST_LEN×DW dual-port RAM with the write side driven by buf_*. The arbiter itself stays flat.

Test Plan:
- CPU read only: idle, cpu_req=1, cpu_addr=0x123, RAM[0x123]=0x5A → issue at T, cpu_ack at T+1 with cpu_rdata=0x5A, no re-grant at T+1.
- Clean burst with BURST_LEN=8, base=0x100, RAM[0x100+i]=i → buf_we for 8 consecutive cycles, buf_addr 0..7, data 0..7; fetch_done with index 7; fetch_busy low next cycle.
- CPU during burst with CPU_GAP=4, BURST_LEN=80, cpu_req raised in the first burst cycle → 4 display reads, then the CPU slot (cpu_ack at slot+1), then reads resume at idx 4; all 80 buffer entries correct.
- Overrun: fetch_start pulsed at burst cycle 10 → fetch_overrun for 1 cycle; burst completes with the original base and 80 writes.
- Address wrap: base=0xFFE, BURST_LEN=4 → mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-burst at idx 20 with a CPU request pending → all outputs 0 next cycle, no cpu_ack, no further buf_we; a new fetch_start after reset runs a full burst.
